// File: rtl/fetch_pkg.sv
// Shared types for the fetch/branch-resolution path: resolve records,
// BTB training writes, the resolve FSM states and the next-PC helper.
package fetch_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        taken;
    logic [31:0] target;
  } resolve_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] target;
  } btb_update_t;

  typedef enum logic [0:0] {
    IDLE,
    SQUASH
  } br_state_e;

  // Architecturally correct next PC; the fall-through add wraps modulo 2^32.
  function automatic logic [31:0] actual_next_pc(input resolve_t r);
    return r.taken ? r.target : r.pc + 32'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// BTB training-write queue. The head is held in an output register and is
// popped on every cycle it is shown, because the BTB write port never stalls.
module btb_update_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  btb_update_t push_data,
  output logic        full,
  output logic        empty,
  output logic        head_valid,
  output btb_update_t head_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  btb_update_t         mem [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic                do_push;
  logic [AW-1:0]       rd_next;
  logic [CW-1:0]       remaining;
  logic [CW-1:0]       count_next;
  btb_update_t         head_next;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Full is judged before this cycle's pop, so a drain frees a slot one cycle later.
  assign do_push = push && !full;

  // Work out what the head register must show after this cycle's pop/push.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_next   = rd_ptr;
    remaining = count;
    if (head_valid) begin
      rd_next   = rd_ptr + AW'(1);
      remaining = count - CW'(1);
    end
    count_next = remaining + CW'(do_push);
    // With nothing left behind the popped head, the incoming entry is next.
    head_next  = (remaining == '0) ? push_data : mem[rd_next];
  end

  // Pointers, occupancy and the registered head.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      // Address/target hold their last value while the queue is empty.
      if (count_next != '0) head_data <= head_next;
    end
  end

  // Entry storage.
  // NOTE: the storage array is not reset; entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: compares resolved next-PC against fetch's
// prediction, pulses a redirect on mismatch, drops wrong-path records for
// FLUSH_CYCLES cycles and queues BTB training writes.
// Optional: define BRANCH_RESOLVE_PERF_EN for saturating perf counters
// perf_resolved / perf_mispredict.
module branch_resolve
  import fetch_pkg::*;
#(
  parameter int unsigned UPDATE_FIFO_DEPTH = 4,
  parameter int unsigned FLUSH_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_pred_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        btb_update_valid,
  output logic [31:0] btb_update_addr,
  output logic [31:0] btb_update_target
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [31:0] perf_resolved,
  output logic [31:0] perf_mispredict
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  br_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  resolve_t    res;
  logic [31:0] actual;
  logic        mispredict;
  logic        accept;
  logic        take_redirect;

  logic        fifo_full;
  logic        fifo_empty;
  btb_update_t fifo_head;

  assign res        = '{pc: res_pc, pred_pc: res_pred_pc, taken: res_taken, target: res_target};
  assign actual     = actual_next_pc(res);
  assign mispredict = (actual != res.pred_pc);
  assign res_ready  = !fifo_full;
  assign accept     = res_valid && res_ready;

  // Next-state logic: evaluate in IDLE, count down the wrong-path window in SQUASH.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    take_redirect = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && mispredict) begin
          take_redirect = 1'b1;
          cnt_d         = CNT_W'(FLUSH_CYCLES);
          state_d       = SQUASH;
        end
      end
      SQUASH: begin
        // Decrements regardless of traffic; leaving on the step that reaches zero.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and squash counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect pulse; the PC stays put until the next redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= take_redirect;
      if (take_redirect) redirect_pc <= actual;
    end
  end

  // Not-taken mispredicts train target pc+4, which acts as a BTB invalidate.
  btb_update_fifo #(
    .DEPTH (UPDATE_FIFO_DEPTH)
  ) u_update_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (take_redirect),
    .push_data  ('{addr: res_pc, target: actual}),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (btb_update_valid),
    .head_data  (fifo_head)
  );

  assign btb_update_addr   = fifo_head.addr;
  assign btb_update_target = fifo_head.target;

  // The update strobe can only be high while the queue holds an entry.
  a_no_update_when_empty : assert property (@(posedge clk) disable iff (rst)
    fifo_empty |-> !btb_update_valid);

`ifdef BRANCH_RESOLVE_PERF_EN
  // Saturating counters over records evaluated in IDLE; squashed records are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_resolved   <= '0;
      perf_mispredict <= '0;
    end else if (accept && state_q == IDLE) begin
      if (perf_resolved != 32'hFFFF_FFFF) perf_resolved <= perf_resolved + 32'd1;
      if (mispredict && perf_mispredict != 32'hFFFF_FFFF)
        perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: two instances (FLUSH_CYCLES 2 and 1) share the
// resolve inputs; each is tracked by a queue-based reference model built
// from the next-PC / squash-window / drain rules.
module tb_branch_resolve;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_pc, res_pred_pc, res_target;
  logic        res_taken;

  logic        rr  [2];
  logic        rv  [2];
  logic [31:0] rpc [2];
  logic        uv  [2];
  logic [31:0] ua  [2];
  logic [31:0] ut  [2];
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] pr  [2];
  logic [31:0] pm  [2];
`endif

  always #5 clk = ~clk;

  branch_resolve #(.UPDATE_FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(2)) dut_f2 (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(rr[0]),
    .res_pc(res_pc), .res_pred_pc(res_pred_pc), .res_taken(res_taken), .res_target(res_target),
    .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
    .btb_update_valid(uv[0]), .btb_update_addr(ua[0]), .btb_update_target(ut[0])
`ifdef BRANCH_RESOLVE_PERF_EN
    , .perf_resolved(pr[0]), .perf_mispredict(pm[0])
`endif
  );

  branch_resolve #(.UPDATE_FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(1)) dut_f1 (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(rr[1]),
    .res_pc(res_pc), .res_pred_pc(res_pred_pc), .res_taken(res_taken), .res_target(res_target),
    .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
    .btb_update_valid(uv[1]), .btb_update_addr(ua[1]), .btb_update_target(ut[1])
`ifdef BRANCH_RESOLVE_PERF_EN
    , .perf_resolved(pr[1]), .perf_mispredict(pm[1])
`endif
  );

  // Reference model state
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          sq_end [2];
  logic        exp_rv [2];
  logic [31:0] exp_rpc[2];
  logic        exp_uv [2];
  logic [31:0] exp_ua [2];
  logic [31:0] exp_ut [2];
  int unsigned exp_pr [2];
  int unsigned exp_pm [2];
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      sq_end[d]  = -1;
      exp_rv[d]  = 1'b0;
      exp_rpc[d] = '0;
      exp_uv[d]  = 1'b0;
      exp_ua[d]  = '0;
      exp_ut[d]  = '0;
      exp_pr[d]  = 0;
      exp_pm[d]  = 0;
    end
  endtask

  // One cycle: compare at the negedge, drive new inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] pred,
                      input logic tk, input logic [31:0] tgt);
    logic [31:0] actual;
    logic [63:0] hd;
    logic        want_rdy;
    logic        acc;
    int          sz;
    for (int d = 0; d < 2; d++) begin
      sz       = (d == 0) ? q0.size() : q1.size();
      want_rdy = (sz < DEPTH);
      tests++;
      if (rr[d] !== want_rdy) begin
        fails++; $display("FAIL res_ready[%0d] cyc %0d: got %b want %b", d, cyc, rr[d], want_rdy);
      end
      tests++;
      if (rv[d] !== exp_rv[d]) begin
        fails++; $display("FAIL redirect_valid[%0d] cyc %0d: got %b want %b", d, cyc, rv[d], exp_rv[d]);
      end
      tests++;
      if (rpc[d] !== exp_rpc[d]) begin
        fails++; $display("FAIL redirect_pc[%0d] cyc %0d: got %h want %h", d, cyc, rpc[d], exp_rpc[d]);
      end
      tests++;
      if (uv[d] !== exp_uv[d]) begin
        fails++; $display("FAIL btb_update_valid[%0d] cyc %0d: got %b want %b", d, cyc, uv[d], exp_uv[d]);
      end
      tests++;
      if ({ua[d], ut[d]} !== {exp_ua[d], exp_ut[d]}) begin
        fails++; $display("FAIL btb_update[%0d] cyc %0d: got %h/%h want %h/%h",
                          d, cyc, ua[d], ut[d], exp_ua[d], exp_ut[d]);
      end
`ifdef BRANCH_RESOLVE_PERF_EN
      tests++;
      if (pr[d] !== exp_pr[d] || pm[d] !== exp_pm[d]) begin
        fails++; $display("FAIL perf[%0d] cyc %0d: got %0d/%0d want %0d/%0d",
                          d, cyc, pr[d], pm[d], exp_pr[d], exp_pm[d]);
      end
`endif
    end

    res_valid   = v;
    res_pc      = pc;
    res_pred_pc = pred;
    res_taken   = tk;
    res_target  = tgt;

    actual = tk ? tgt : pc + 32'd4;
    for (int d = 0; d < 2; d++) begin
      sz  = (d == 0) ? q0.size() : q1.size();
      acc = v && (sz < DEPTH);
      // The entry shown this cycle is written into the BTB and leaves the queue.
      if (sz > 0) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      exp_rv[d] = 1'b0;
      if (acc && cyc > sq_end[d]) begin
        exp_pr[d]++;
        if (actual != pred) begin
          exp_pm[d]++;
          exp_rv[d]  = 1'b1;
          exp_rpc[d] = actual;
          sq_end[d]  = cyc + ((d == 0) ? 2 : 1);
          if (d == 0) q0.push_back({pc, actual}); else q1.push_back({pc, actual});
        end
      end
      sz = (d == 0) ? q0.size() : q1.size();
      exp_uv[d] = (sz > 0);
      if (sz > 0) begin
        hd = (d == 0) ? q0[0] : q1[0];
        exp_ua[d] = hd[63:32];
        exp_ut[d] = hd[31:0];
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res_valid = 1'b0; res_pc = '0; res_pred_pc = '0; res_taken = 1'b0; res_target = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rr[d] !== 1'b1 || rv[d] !== 1'b0 || rpc[d] !== 32'h0 ||
          uv[d] !== 1'b0 || ua[d] !== 32'h0 || ut[d] !== 32'h0) begin
        fails++; $display("FAIL reset_values[%0d]: got rdy=%b rv=%b rpc=%h uv=%b ua=%h ut=%h want 1 0 0 0 0 0",
                          d, rr[d], rv[d], rpc[d], uv[d], ua[d], ut[d]);
      end
    end
    model_reset();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    // Correct not-taken prediction: nothing happens.
    step(1'b1, 32'h100, 32'h104, 1'b0, 32'h0);
    tests++;
    if (rv[0] !== 1'b0 || uv[0] !== 1'b0) begin
      fails++; $display("FAIL correct_pred: got rv=%b uv=%b want 0 0", rv[0], uv[0]);
    end
    idle(2);
    // Taken mispredict at N.
    step(1'b1, 32'h100, 32'h104, 1'b1, 32'h200);
    tests++;
    if (rv[0] !== 1'b1 || rpc[0] !== 32'h200 || uv[0] !== 1'b1 ||
        ua[0] !== 32'h100 || ut[0] !== 32'h200) begin
      fails++; $display("FAIL taken_mispredict: got rv=%b rpc=%h uv=%b upd=%h/%h want 1 200 1 100/200",
                        rv[0], rpc[0], uv[0], ua[0], ut[0]);
    end
    // N+1 and N+2 are wrong-path on the FLUSH_CYCLES=2 instance.
    step(1'b1, 32'h500, 32'h0, 1'b0, 32'h0);
    step(1'b1, 32'h600, 32'h0, 1'b0, 32'h0);
    tests++;
    if (rv[0] !== 1'b0) begin
      fails++; $display("FAIL squash_drop: got rv=%b want 0", rv[0]);
    end
    // N+3 is evaluated: not-taken mispredict trains pc+4.
    step(1'b1, 32'h300, 32'h800, 1'b0, 32'h0);
    tests++;
    if (rv[0] !== 1'b1 || rpc[0] !== 32'h304 || uv[0] !== 1'b1 ||
        ua[0] !== 32'h300 || ut[0] !== 32'h304) begin
      fails++; $display("FAIL nt_mispredict: got rv=%b rpc=%h uv=%b upd=%h/%h want 1 304 1 300/304",
                        rv[0], rpc[0], uv[0], ua[0], ut[0]);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tests++;
    if (uv[0] !== 1'b0 || rpc[0] !== 32'h304 || ua[0] !== 32'h300) begin
      fails++; $display("FAIL update_gone: got uv=%b rpc=%h ua=%h want 0 304 300", uv[0], rpc[0], ua[0]);
    end
    idle(3);
    // Fall-through wraps to zero: correct prediction.
    step(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
    tests++;
    if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin
      fails++; $display("FAIL wrap: got rv=%b/%b want 0/0", rv[0], rv[1]);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    int          n_redir = 0;
    int          n_upd   = 0;
    logic        rdy_ok  = 1'b1;
    logic        ord_ok  = 1'b1;
    logic [31:0] want_addr;
    for (int i = 0; i < 13; i++) begin
      if (i < 12) step(1'b1, 32'h1000 + 32'(8 * i), 32'hDEAD_0000, 1'b0, 32'h0);
      else        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      if (rr[1] !== 1'b1) rdy_ok = 1'b0;
      if (rv[1] === 1'b1) n_redir++;
      if (uv[1] === 1'b1) begin
        want_addr = 32'h1000 + 32'(16 * n_upd);
        if (ua[1] !== want_addr || ut[1] !== want_addr + 32'd4) ord_ok = 1'b0;
        n_upd++;
      end
    end
    tests++;
    if (n_redir != 6 || n_upd != 6) begin
      fails++; $display("FAIL b2b_count: got redirects=%0d updates=%0d want 6 6", n_redir, n_upd);
    end
    tests++;
    if (!ord_ok || !rdy_ok) begin
      fails++; $display("FAIL b2b_order_ready: got order_ok=%b ready_ok=%b want 1 1", ord_ok, rdy_ok);
    end
    idle(3);
  endtask

  task automatic test_random();
    logic        v, tk;
    logic [31:0] pc, tgt, pred, actual;
    for (int i = 0; i < 500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      tk  = $urandom_range(0, 1) == 1;
      tgt = $urandom() & 32'hFFFF_FFFC;
      actual = tk ? tgt : pc + 32'd4;
      pred = ($urandom_range(0, 1) == 1) ? actual : ($urandom() & 32'hFFFF_FFFC);
      step(v, pc, pred, tk, tgt);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    idle(3);
    step(1'b1, 32'h700, 32'h0, 1'b1, 32'h900);
    step(1'b1, 32'h800, 32'h0, 1'b1, 32'hA00);
    // Both instances now hold pending state; reset acts without waiting for a clock.
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rr[d] !== 1'b1 || rv[d] !== 1'b0 || rpc[d] !== 32'h0 ||
          uv[d] !== 1'b0 || ua[d] !== 32'h0 || ut[d] !== 32'h0) begin
        fails++; $display("FAIL reset_mid[%0d]: got rdy=%b rv=%b rpc=%h uv=%b ua=%h ut=%h want 1 0 0 0 0 0",
                          d, rr[d], rv[d], rpc[d], uv[d], ua[d], ut[d]);
      end
    end
    res_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(2);
    // Evaluation resumes immediately in IDLE after reset.
    step(1'b1, 32'h40, 32'h44, 1'b1, 32'h80);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
